// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter that lets the instruction master (m0) and the data
// master (m1) share one single-port RAM. At most one RAM command is issued
// per cycle. A tag pipeline routes read data back to the master that issued
// the read, in issue order.
module onchip_mem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic w_m0_req;
  logic w_m1_req;
  logic w_gnt0;
  logic w_gnt1;
  logic w_rd_issue;

  // 1 = m1 was granted most recently; resets to m1 so m0 wins the first tie
  logic r_last_grant;

  // Read tag pipeline: index 0 is captured at issue, top index is the response stage
  logic [READ_LATENCY-1:0] r_tag_vld;
  logic [READ_LATENCY-1:0] r_tag_id;

  assign w_m0_req = m0_read | m0_write;
  assign w_m1_req = m1_read | m1_write;

  // Arbitration: a lone requester wins; on a tie the master not granted last wins.
  // No grant while reset is held, so both masters see waitrequest high.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset_n) begin
      if (w_m0_req && (!w_m1_req || r_last_grant)) begin
        w_gnt0 = 1'b1;
      end else if (w_m1_req) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign m0_waitrequest = ~w_gnt0;
  assign m1_waitrequest = ~w_gnt1;

  // Steer the winner's command onto the RAM port; m0 drives the don't-care fields when idle
  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    if (w_gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end
    mem_chipselect = w_gnt0 | w_gnt1;
    // read+write together on one master is treated as a write
    mem_write      = (w_gnt0 & m0_write) | (w_gnt1 & m1_write);
  end

  assign w_rd_issue = mem_chipselect & ~mem_write;
  assign mem_clken  = 1'b1;

  // Remember who won, only on cycles that actually grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
    end else if (w_gnt0) begin
      r_last_grant <= 1'b0;
    end else if (w_gnt1) begin
      r_last_grant <= 1'b1;
    end
  end

  // Shift {read issued, winner id} down the tag pipeline every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld[0] <= w_rd_issue;
      r_tag_id[0]  <= w_gnt1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  assign m0_readdatavalid = r_tag_vld[READ_LATENCY-1] & ~r_tag_id[READ_LATENCY-1];
  assign m1_readdatavalid = r_tag_vld[READ_LATENCY-1] &  r_tag_id[READ_LATENCY-1];

  // Both masters see the RAM output; only the matching readdatavalid qualifies it
  assign m0_readdata = mem_readdata;
  assign m1_readdata = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter: one instance with READ_LATENCY=1
// (u_dut_a) and one with READ_LATENCY=3 (u_dut_b), each in front of a small
// behavioural byte-enabled RAM with the matching read latency.
module tb_onchip_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- instance A (latency 1) ----------------
  logic        a_rst_n;
  logic [11:0] a_m0_addr, a_m1_addr, a_mem_addr;
  logic [3:0]  a_m0_be, a_m1_be, a_mem_be;
  logic        a_m0_rd, a_m0_wr, a_m1_rd, a_m1_wr;
  logic [31:0] a_m0_wd, a_m1_wd, a_mem_wd, a_mem_rdata;
  logic        a_m0_wait, a_m1_wait, a_m0_rdv, a_m1_rdv;
  logic [31:0] a_m0_rdata, a_m1_rdata;
  logic        a_mem_cs, a_mem_we, a_mem_clken;

  onchip_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .READ_LATENCY(1)) u_dut_a (
    .clk(clk), .reset_n(a_rst_n),
    .m0_address(a_m0_addr), .m0_byteenable(a_m0_be), .m0_read(a_m0_rd), .m0_write(a_m0_wr),
    .m0_writedata(a_m0_wd), .m0_waitrequest(a_m0_wait), .m0_readdata(a_m0_rdata),
    .m0_readdatavalid(a_m0_rdv),
    .m1_address(a_m1_addr), .m1_byteenable(a_m1_be), .m1_read(a_m1_rd), .m1_write(a_m1_wr),
    .m1_writedata(a_m1_wd), .m1_waitrequest(a_m1_wait), .m1_readdata(a_m1_rdata),
    .m1_readdatavalid(a_m1_rdv),
    .mem_address(a_mem_addr), .mem_byteenable(a_mem_be), .mem_chipselect(a_mem_cs),
    .mem_write(a_mem_we), .mem_writedata(a_mem_wd), .mem_clken(a_mem_clken),
    .mem_readdata(a_mem_rdata)
  );

  logic [31:0] ram_a [0:4095];
  always @(posedge clk) begin
    if (a_mem_cs && a_mem_we)
      for (int i = 0; i < 4; i++)
        if (a_mem_be[i]) ram_a[a_mem_addr][8*i +: 8] <= a_mem_wd[8*i +: 8];
    a_mem_rdata <= ram_a[a_mem_addr];
  end

  // ---------------- instance B (latency 3) ----------------
  logic        b_rst_n;
  logic [11:0] b_m0_addr, b_m1_addr, b_mem_addr;
  logic [3:0]  b_m0_be, b_m1_be, b_mem_be;
  logic        b_m0_rd, b_m0_wr, b_m1_rd, b_m1_wr;
  logic [31:0] b_m0_wd, b_m1_wd, b_mem_wd, b_mem_rdata, b_p1, b_p2;
  logic        b_m0_wait, b_m1_wait, b_m0_rdv, b_m1_rdv;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_mem_cs, b_mem_we, b_mem_clken;

  onchip_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .READ_LATENCY(3)) u_dut_b (
    .clk(clk), .reset_n(b_rst_n),
    .m0_address(b_m0_addr), .m0_byteenable(b_m0_be), .m0_read(b_m0_rd), .m0_write(b_m0_wr),
    .m0_writedata(b_m0_wd), .m0_waitrequest(b_m0_wait), .m0_readdata(b_m0_rdata),
    .m0_readdatavalid(b_m0_rdv),
    .m1_address(b_m1_addr), .m1_byteenable(b_m1_be), .m1_read(b_m1_rd), .m1_write(b_m1_wr),
    .m1_writedata(b_m1_wd), .m1_waitrequest(b_m1_wait), .m1_readdata(b_m1_rdata),
    .m1_readdatavalid(b_m1_rdv),
    .mem_address(b_mem_addr), .mem_byteenable(b_mem_be), .mem_chipselect(b_mem_cs),
    .mem_write(b_mem_we), .mem_writedata(b_mem_wd), .mem_clken(b_mem_clken),
    .mem_readdata(b_mem_rdata)
  );

  logic [31:0] ram_b [0:4095];
  always @(posedge clk) begin
    if (b_mem_cs && b_mem_we)
      for (int i = 0; i < 4; i++)
        if (b_mem_be[i]) ram_b[b_mem_addr][8*i +: 8] <= b_mem_wd[8*i +: 8];
    b_p1        <= ram_b[b_mem_addr];
    b_p2        <= b_p1;
    b_mem_rdata <= b_p2;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic a_set(input logic r0, input logic w0, input logic [11:0] ad0, input logic [3:0] be0,
                       input logic [31:0] wd0, input logic r1, input logic w1, input logic [11:0] ad1,
                       input logic [3:0] be1, input logic [31:0] wd1);
    a_m0_rd = r0; a_m0_wr = w0; a_m0_addr = ad0; a_m0_be = be0; a_m0_wd = wd0;
    a_m1_rd = r1; a_m1_wr = w1; a_m1_addr = ad1; a_m1_be = be1; a_m1_wd = wd1;
  endtask

  task automatic b_set(input logic r0, input logic w0, input logic [11:0] ad0, input logic [31:0] wd0,
                       input logic r1, input logic w1, input logic [11:0] ad1, input logic [31:0] wd1);
    b_m0_rd = r0; b_m0_wr = w0; b_m0_addr = ad0; b_m0_be = 4'hF; b_m0_wd = wd0;
    b_m1_rd = r1; b_m1_wr = w1; b_m1_addr = ad1; b_m1_be = 4'hF; b_m1_wd = wd1;
  endtask

  initial begin
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    a_set(1, 0, 12'h001, 4'hF, 0, 1, 0, 12'h002, 4'hF, 0);
    b_set(0, 0, 0, 0, 0, 0, 0, 0);

    // ---- reset with both masters reading ----
    repeat (2) tick();
    mid();
    chk("rst_w0", a_m0_wait, 1);
    chk("rst_w1", a_m1_wait, 1);
    chk("rst_cs", a_mem_cs, 0);
    chk("rst_rdv0", a_m0_rdv, 0);
    chk("rst_rdv1", a_m1_rdv, 0);
    chk("rst_clken", a_mem_clken, 1);
    chk("rst_b_w0", b_m0_wait, 1);
    chk("rst_b_clken", b_mem_clken, 1);
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    mid();
    chk("first_w0", a_m0_wait, 0);
    chk("first_w1", a_m1_wait, 1);
    chk("first_addr", a_mem_addr, 12'h001);
    tick();
    a_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    // ---- preload A: m0 writes 0x001, m1 writes 0x002 (last grant ends on m1) ----
    a_set(0, 1, 12'h001, 4'hF, 32'h11111111, 0, 0, 0, 0, 0);
    tick();
    a_set(0, 0, 0, 0, 0, 0, 1, 12'h002, 4'hF, 32'h22222222);
    tick();

    // ---- contention: grants alternate m0, m1, ... ----
    a_set(1, 0, 12'h001, 4'hF, 0, 1, 0, 12'h002, 4'hF, 0);
    for (int k = 0; k < 8; k++) begin
      mid();
      chk("cont_w0", a_m0_wait, (k % 2 == 0) ? 0 : 1);
      chk("cont_w1", a_m1_wait, (k % 2 == 0) ? 1 : 0);
      chk("cont_addr", a_mem_addr, (k % 2 == 0) ? 12'h001 : 12'h002);
      chk("cont_rdv0", a_m0_rdv, (k % 2 == 1) ? 1 : 0);
      chk("cont_rdv1", a_m1_rdv, (k >= 2 && k % 2 == 0) ? 1 : 0);
      if (k % 2 == 1) chk("cont_d0", a_m0_rdata, 32'h11111111);
      if (k >= 2 && k % 2 == 0) chk("cont_d1", a_m1_rdata, 32'h22222222);
      tick();
    end
    a_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    // ---- single write then read ----
    a_set(0, 1, 12'h010, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    mid();
    chk("wr_w0", a_m0_wait, 0);
    chk("wr_cs", a_mem_cs, 1);
    chk("wr_we", a_mem_we, 1);
    chk("wr_wd", a_mem_wd, 32'hDEADBEEF);
    tick();
    a_set(1, 0, 12'h010, 4'hF, 0, 0, 0, 0, 0, 0);
    mid();
    chk("rd_cs", a_mem_cs, 1);
    chk("rd_we", a_mem_we, 0);
    chk("rd_norsp", a_m0_rdv, 0);
    tick();
    a_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("rd_rdv0", a_m0_rdv, 1);
    chk("rd_data", a_m0_rdata, 32'hDEADBEEF);
    chk("rd_rdv1", a_m1_rdv, 0);
    tick();
    mid();
    chk("rd_pulse", a_m0_rdv, 0);
    chk("idle_cs", a_mem_cs, 0);
    chk("idle_we", a_mem_we, 0);
    tick();

    // ---- byte-lane write ----
    a_set(0, 1, 12'h020, 4'hF, 32'hAABBCCDD, 0, 0, 0, 0, 0);
    tick();
    a_set(0, 0, 0, 0, 0, 0, 1, 12'h020, 4'h1, 32'h00000055);
    mid();
    chk("bw_w1", a_m1_wait, 0);
    chk("bw_be", a_mem_be, 4'h1);
    chk("bw_addr", a_mem_addr, 12'h020);
    tick();
    a_set(1, 0, 12'h020, 4'hF, 0, 0, 0, 0, 0, 0);
    tick();
    a_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("bw_rdv0", a_m0_rdv, 1);
    chk("bw_data", a_m0_rdata, 32'hAABBCC55);
    tick();

    // ---- read+write together on m1: write wins, no response ----
    a_set(0, 0, 0, 0, 0, 1, 1, 12'h030, 4'hF, 32'h12345678);
    mid();
    chk("ww_we", a_mem_we, 1);
    tick();
    a_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("ww_rdv1", a_m1_rdv, 0);
    tick();
    a_set(1, 0, 12'h030, 4'hF, 0, 0, 0, 0, 0, 0);
    tick();
    a_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("ww_data", a_m0_rdata, 32'h12345678);
    tick();

    // ---- lone requester granted every cycle ----
    a_set(0, 0, 0, 0, 0, 1, 0, 12'h002, 4'hF, 0);
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("solo_w1", a_m1_wait, 0);
      chk("solo_rdv1", a_m1_rdv, (k >= 1) ? 1 : 0);
      tick();
    end
    a_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    // ---- B: preload, then reset with reads in flight, then latency-3 ordering ----
    b_set(0, 1, 12'h001, 32'h11111111, 0, 0, 0, 0);
    tick();
    b_set(0, 0, 0, 0, 0, 1, 12'h002, 32'h22222222);
    tick();
    b_set(0, 0, 0, 0, 1, 0, 12'h002, 0);     // m1 read
    tick();
    b_set(1, 0, 12'h001, 0, 0, 0, 0, 0);     // m0 read, last grant now m0
    tick();
    b_set(0, 0, 0, 0, 0, 0, 0, 0);
    b_rst_n = 1'b0;
    #2;
    b_rst_n = 1'b1;
    mid();
    chk("rip_rdv0_t1", b_m0_rdv, 0);
    chk("rip_rdv1_t1", b_m1_rdv, 0);
    tick();
    b_set(1, 0, 12'h001, 0, 1, 0, 12'h002, 0);
    for (int k = 0; k < 8; k++) begin
      mid();
      if (k < 4) chk("l3_w0", b_m0_wait, (k % 2 == 0) ? 0 : 1);
      chk("l3_rdv0", b_m0_rdv, (k == 3 || k == 5) ? 1 : 0);
      chk("l3_rdv1", b_m1_rdv, (k == 4 || k == 6) ? 1 : 0);
      if (k == 3 || k == 5) chk("l3_d0", b_m0_rdata, 32'h11111111);
      if (k == 4 || k == 6) chk("l3_d1", b_m1_rdata, 32'h22222222);
      tick();
      if (k == 3) b_set(0, 0, 0, 0, 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-port round-robin arbiter sharing one single-port on-chip RAM (4096 x 32, byte-enabled, 1-cycle read latency) between two Avalon-MM masters: the instruction master (m0) and the data master (m1). It sits between the processor's master ports and the RAM slave. It issues at most one RAM command per cycle. Read data returns with `readdatavalid` only to the master that issued the read, in issue order.

## Interface
Parameters:
- ADDR_W, 12, RAM word-address width
- DATA_W, 32, data width; byteenable width = DATA_W/8
- READ_LATENCY, 1, RAM cycles from read command to valid `mem_readdata`; legal range 1..4

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous active-low reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  DATA_W/8  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_clken  out  1  RAM clock enable; constant 1
- mem_readdata  in  DATA_W  from RAM

## Operation
- Request: mN_req = mN_read | mN_write. Read and write asserted together on one master is illegal; if it occurs, write wins.
- Arbitration is combinational within the cycle:
  - Only one requester: it is granted.
  - Both requesting: the master not granted most recently wins.
  - `last_grant` register updates only on an actual grant.
  - Reset value of `last_grant` = m1, so m0 wins the first tie.
- Granted master: waitrequest = 0 and its command drives the mem_* outputs with mem_chipselect = 1.
- Losing or idle master: waitrequest = 1. A master must hold its command stable until waitrequest = 0 (Avalon rule; not checked).
- No grant: mem_chipselect = 0, mem_write = 0. mem_address, mem_byteenable and mem_writedata hold don't-care values and are driven from m0.
- Read tag pipeline: a shift register READ_LATENCY deep of {valid, id}.
  - Each cycle it shifts in {granted & read, winner id}.
  - At the output stage: valid & id = N gives mN_readdatavalid = 1.
- m0_readdata and m1_readdata are both wired to mem_readdata; they are meaningful only when the matching readdatavalid is high.
- Writes produce no response. A write occupies the RAM for one cycle.
- Back-to-back commands are fully pipelined: reads can be issued every cycle, alternating masters under contention, with no bubbles.

## Timing
- Read issued (granted) in cycle T → mN_readdatavalid = 1 in cycle T+READ_LATENCY, exactly one cycle wide.
- Responses are in order. The two masters never receive readdatavalid in the same cycle.
- Write granted in cycle T: the RAM is updated at the clk edge ending T. A read of the same address granted in T+1 returns the new data.
- During reset_n = 0, all flops clear asynchronously: tag pipeline valid bits = 0, last_grant = m1.
- Outputs during reset: m0/m1_readdatavalid = 0, mem_chipselect = 0, m0/m1_waitrequest = 1 (forced while reset_n is low), mem_clken = 1.
- Reset mid-operation: in-flight reads are dropped. No readdatavalid is issued for them after reset_n deasserts.
- First grant is possible in the first cycle with reset_n high.
- Single requester under continuous requests: granted every cycle, no fairness stall.

## Test plan
- Reset: hold reset_n = 0 with both masters reading → waitrequest 1/1, mem_chipselect 0, no readdatavalid. After release, m0 is granted first.
- Single read: m0 writes 0xDEADBEEF to 0x010 with byteenable 0xF, then reads 0x010 → m0_readdatavalid one cycle after grant with readdata 0xDEADBEEF. m1_readdatavalid stays 0.
- Contention: both masters read continuously (m0 at 0x001, m1 at 0x002, preloaded 0x11111111 and 0x22222222) → grants alternate m0, m1, m0, …. Each master gets one readdatavalid every 2 cycles with its own data.
- Byte write: 0xAABBCCDD at 0x020, then m1 writes 0x00000055 with byteenable 0x1, then m0 reads 0x020 → 0xAABBCC55.
- Reset with read in flight: m1 read granted, reset_n pulses low before return → no m1_readdatavalid afterwards, and the arbiter restarts with m0 priority.
- READ_LATENCY = 3 build: 4 back-to-back reads (m0, m1, m0, m1) → readdatavalid pulses in the same order, each exactly 3 cycles after its grant.
